fixed_int_div: RTL
==================

FIXED_INT_DIV -- requirements
Module: fixed_int_div

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (two's complement), legal range 4..32.
REQ-002 SHALL have parameter DEC_POINT_POS, default 4, number of fractional bits in A, B and Q, legal range 0..WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: A/B operand pair offered.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept an operand pair.
REQ-007 SHALL have port A, input, WIDTH bits: signed fixed-point dividend.
REQ-008 SHALL have port B, input, WIDTH bits: signed fixed-point divisor.
REQ-009 SHALL have port out_valid, output, 1 bit: Q/Rem/div_by_zero valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port Q, output, 2*WIDTH bits: signed fixed-point quotient with DEC_POINT_POS fractional bits.
REQ-012 SHALL have port Rem, output, WIDTH bits: signed remainder, in units of 2^-DEC_POINT_POS of the dividend LSB.
REQ-013 SHALL have port div_by_zero, output, 1 bit: B was zero for this result.
REQ-014 SHALL have port busy, output, 1 bit: high while in state CALC.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; an operand pair is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-017 SHALL, on accept, register sign_q=A[MSB]^B[MSB] and sign_r=A[MSB], plus WIDTH-bit magnitudes |A| and |B|; -2^(WIDTH-1) SHALL give magnitude 2^(WIDTH-1) (no wrap to 0).
REQ-018 SHALL form numerator N=|A|<<DEC_POINT_POS, NW=WIDTH+DEC_POINT_POS bits wide.
REQ-019 SHALL, on accept with B!=0, enter CALC and perform unsigned restoring division of N by |B|, one quotient bit per clock, MSB first, for exactly NW cycles; a counter tracks the iterations.
REQ-020 SHALL enter DONE on the edge completing iteration NW, so out_valid rises NW cycles after the accepting edge.
REQ-021 SHALL, on accept with B==0, go directly to DONE (out_valid on the next cycle) with Q=0, Rem=0, div_by_zero=1.
REQ-022 SHALL output Q = sign_q ? -(quotient magnitude) : quotient magnitude, sign-extended to 2*WIDTH bits; truncation is toward zero.
REQ-023 SHALL output Rem = sign_r ? -(remainder magnitude) : remainder magnitude, so that N_signed = Q*B + Rem in scaled units; zero magnitude yields 0, never negative zero.
REQ-024 SHALL hold Q, Rem, div_by_zero and out_valid=1 stable in DONE until an edge with out_ready=1, then return to IDLE; no accept occurs on that same edge.
REQ-025 SHALL ignore in_valid, A and B in CALC and DONE; a changing input mid-CALC SHALL NOT affect the result.
REQ-026 SHALL clear div_by_zero to 0 for every result with B!=0.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, iteration counter 0, in_ready=1, out_valid=0, busy=0, Q=0, Rem=0, div_by_zero=0, regardless of clk.
REQ-028 SHALL abandon any CALC or DONE operation on reset; the first accept after rst deasserts starts a fresh operation.

Verification (WIDTH=8, DEC_POINT_POS=4, NW=12)
REQ-029 SHALL cover A=0x30 (3.0), B=0x20 (2.0) -> out_valid 12 cycles after accept, Q=0x0018 (1.5), Rem=0x00, div_by_zero=0.
REQ-030 SHALL cover signs: A=0xD0, B=0x20 -> Q=0xFFE8; A=0xF9, B=0x03 -> Q=0xFFDB, Rem=0xFF; A=0x07, B=0x03 -> Q=0x0025, Rem=0x01.
REQ-031 SHALL cover most-negative: A=0x80, B=0xF0 -> Q=0x0080, Rem=0x00; A=0x80, B=0x10 -> Q=0xFF80.
REQ-032 SHALL cover divide-by-zero: A=0x55, B=0x00 -> out_valid the cycle after accept, Q=0x0000, Rem=0x00, div_by_zero=1; the next normal divide clears div_by_zero.
REQ-033 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and changing A/B -> outputs stable, in_ready=0, no new accept; out_ready=1 -> IDLE, then in_ready=1.
REQ-034 SHALL cover reset mid-CALC: rst pulsed at iteration 6 -> immediate IDLE, out_valid=0, busy=0, Q=0; next operation returns the correct result.

Source files
------------

// File: rtl/fixed_int_div.sv
// Signed fixed-point divider: sign/magnitude restoring division, one quotient bit
// per clock, with valid/ready handshakes on both the operand and result sides.
module fixed_int_div #(
    parameter int WIDTH         = 8,
    parameter int DEC_POINT_POS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]     Rem,
    output logic                 div_by_zero,
    output logic                 busy
);

    localparam int NW = WIDTH + DEC_POINT_POS;
    localparam int CW = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              sign_q, sign_r;
    logic [WIDTH-1:0]  mag_b;
    logic [WIDTH-1:0]  rem_p;
    logic [NW-1:0]     num_p;
    logic              accept, last_iter, b_zero;
    logic [WIDTH:0]    trial, diff;
    logic              qbit;
    logic [WIDTH-1:0]  rem_nxt;
    logic [NW-1:0]     num_nxt;

    // The most negative input maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] signed_quot(input logic [NW-1:0] m, input logic s);
        logic signed [2*WIDTH-1:0] e;
        e = (2*WIDTH)'(m);
        return s ? -e : e;
    endfunction

    function automatic logic [WIDTH-1:0] signed_rem(input logic [WIDTH-1:0] m, input logic s);
        logic signed [WIDTH-1:0] e;
        e = m;
        return s ? -e : e;
    endfunction

    assign accept    = (state == IDLE) && in_valid;
    assign b_zero    = (B == '0);
    assign last_iter = (cnt == CW'(NW - 1));

    // Partial remainder stays below |B| <= 2^(WIDTH-1), so one extra bit covers the shift.
    always_comb begin
        trial   = {rem_p, num_p[NW-1]};
        diff    = trial - {1'b0, mag_b};
        qbit    = (trial >= {1'b0, mag_b});
        rem_nxt = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        num_nxt = {num_p[NW-2:0], qbit};
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = b_zero ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)             cnt <= '0;
            else if (state == CALC) cnt <= cnt + CW'(1);
        end
    end

    // The numerator shift register collects quotient bits as dividend bits leave it.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
            sign_r <= A[WIDTH-1];
            mag_b  <= magnitude(B);
            num_p  <= NW'(magnitude(A)) << DEC_POINT_POS;
            rem_p  <= '0;
        end else if (state == CALC) begin
            num_p  <= num_nxt;
            rem_p  <= rem_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q           <= '0;
            Rem         <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && b_zero) begin
            Q           <= '0;
            Rem         <= '0;
            div_by_zero <= 1'b1;
        end else if (state == CALC && last_iter) begin
            Q           <= signed_quot(num_nxt, sign_q);
            Rem         <= signed_rem(rem_nxt, sign_r);
            div_by_zero <= 1'b0;
        end
    end

endmodule
